// File: rtl/fnd_sum_display.sv
// fnd_sum_display
// Takes the 9-bit adder result {co, so}, converts it to BCD with an iterative
// double-dabble (one shift per clock), and drives a 4-digit common-anode
// 7-segment display by time-multiplexing the digit enables.
// The displayed value only changes once a conversion has fully completed.

module fnd_sum_display #(
    parameter int SCAN_DIV = 100_000,   // clocks per digit slot (>= 2)
    parameter bit BLANK_LZ = 1'b1       // 1: blank leading zeros
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sum_vld,
    input  logic [8:0]  sum_in,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_font
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;

    logic [8:0]    bin_r;         // binary bits still to be shifted in
    logic [11:0]   bcd_r;         // BCD scratch, invisible until done
    logic [3:0]    step_r;        // shift steps already taken
    logic [11:0]   bcd_out_r;     // last completed result

    logic [CW-1:0] scan_cnt_r;
    logic [1:0]    dig_idx_r;

    logic          start_s;
    logic          last_step_s;
    logic [11:0]   bcd_adj_s;
    logic [20:0]   shift_s;
    logic [3:0]    digit_s;
    logic          blank_s;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // doubling, so bias it by 3 before the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dp never lit.
    function automatic logic [7:0] seg_font(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Control strobes: accept a new sum only when idle; flag the ninth shift.
    always_comb begin
        start_s     = (state_r == ST_IDLE) && sum_vld;
        last_step_s = (state_r == ST_CONV) && (step_r == 4'd8);
    end

    // One double-dabble step: adjust each BCD nibble, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj_s = {dabble_adj(bcd_r[11:8]), dabble_adj(bcd_r[7:4]), dabble_adj(bcd_r[3:0])};
        shift_s   = {bcd_adj_s, bin_r} << 1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: IDLE -> CONV on a strobe, CONV -> IDLE after nine shifts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sum_vld) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (step_r == 4'd8) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: busy is simply "conversion in flight".
    always_comb begin
        busy = 1'b0;
        case (state_r)
            ST_IDLE: busy = 1'b0;
            ST_CONV: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Conversion datapath: load on accept, shift once per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r  <= 9'd0;
            bcd_r  <= 12'h000;
            step_r <= 4'd0;
        end else if (start_s) begin
            bin_r  <= sum_in;
            bcd_r  <= 12'h000;
            step_r <= 4'd0;
        end else if (state_r == ST_CONV) begin
            bcd_r  <= shift_s[20:9];
            bin_r  <= shift_s[8:0];
            step_r <= step_r + 4'd1;
        end else begin
            bin_r  <= bin_r;
            bcd_r  <= bcd_r;
            step_r <= step_r;
        end
    end

    // Published result: updated only on the final shift so the display never
    // sees partial data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out_r <= 12'h000;
        end else if (last_step_s) begin
            bcd_out_r <= shift_s[20:9];
        end else begin
            bcd_out_r <= bcd_out_r;
        end
    end

    assign bcd_out = bcd_out_r;

    // Free-running scan timer; advances the digit index once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= 2'd0;
        end else if (scan_cnt_r == CW'(SCAN_DIV - 1)) begin
            scan_cnt_r <= '0;
            dig_idx_r  <= dig_idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
            dig_idx_r  <= dig_idx_r;
        end
    end

    // Digit select and leading-zero detection for the current slot.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        case (dig_idx_r)
            2'd0: begin
                digit_s = bcd_out_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = bcd_out_r[7:4];
                blank_s = (bcd_out_r[11:8] == 4'd0) && (bcd_out_r[7:4] == 4'd0);
            end
            2'd2: begin
                digit_s = bcd_out_r[11:8];
                blank_s = (bcd_out_r[11:8] == 4'd0);
            end
            2'd3: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b0;
            end
        endcase
    end

    // Pin drive: active-low one-hot digit enable plus segment pattern.
    always_comb begin
        fnd_com  = 4'b1110;
        fnd_font = 8'hFF;
        case (dig_idx_r)
            2'd0:    fnd_com = 4'b1110;
            2'd1:    fnd_com = 4'b1101;
            2'd2:    fnd_com = 4'b1011;
            2'd3:    fnd_com = 4'b0111;
            default: fnd_com = 4'b1110;
        endcase
        if (BLANK_LZ && blank_s) begin
            fnd_font = 8'hFF;
        end else begin
            fnd_font = seg_font(digit_s);
        end
    end

endmodule

// File: tb/tb_fnd_sum_display.sv
// Scoreboard bench for fnd_sum_display: stimulus pushes the expected BCD
// result into a queue; a monitor pops and compares each time busy falls.
// Display scanning is compared against an independent scan model.

module tb_fnd_sum_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sum_vld = 1'b0;
    logic [8:0]  sum_in = 9'd0;

    logic        busy, busy2;
    logic [11:0] bcd_out, bcd_out2;
    logic [3:0]  fnd_com, fnd_com2;
    logic [7:0]  fnd_font, fnd_font2;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];

    int          m_cnt = 0;
    logic        m_prev = 1'b0;
    int          scan_c;
    logic [1:0]  scan_i;

    always #5 clk = ~clk;

    fnd_sum_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sum_vld(sum_vld), .sum_in(sum_in),
        .busy(busy), .bcd_out(bcd_out), .fnd_com(fnd_com), .fnd_font(fnd_font)
    );

    fnd_sum_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nolz (
        .clk(clk), .rst_n(rst_n), .sum_vld(sum_vld), .sum_in(sum_in),
        .busy(busy2), .bcd_out(bcd_out2), .fnd_com(fnd_com2), .fnd_font(fnd_font2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] font(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Reference scan timer: slot of SD clocks, digit index wraps 0..3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_c <= 0;
            scan_i <= 2'd0;
        end else if (scan_c == SD - 1) begin
            scan_c <= 0;
            scan_i <= scan_i + 2'd1;
        end else begin
            scan_c <= scan_c + 1;
        end
    end

    // Monitor: on each busy falling edge, check busy length and result.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_prev = 1'b0;
        end else begin
            if (busy) m_cnt++;
            if (m_prev && !busy) begin
                check("busy_len", m_cnt, 9);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", bcd_out);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("bcd_out", bcd_out, e);
                    check("bcd_out_nolz", bcd_out2, e);
                end
                m_cnt = 0;
            end
            m_prev = busy;
        end
    end

    task automatic send(input logic [8:0] v, input logic [11:0] e);
        @(posedge clk); #1;
        sum_in  = v;
        sum_vld = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sum_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=1 expected busy=0 within 40 clocks");
        end
    endtask

    // Compare both instances' pin drive against the scan model for ncyc clocks.
    task automatic check_display(input int v, input int ncyc);
        int dg[4];
        logic [3:0] ecom;
        logic       blank;
        dg[0] = v % 10;
        dg[1] = (v / 10) % 10;
        dg[2] = v / 100;
        dg[3] = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            ecom  = ~(4'b0001 << scan_i);
            blank = (scan_i == 2'd3) ||
                    (scan_i == 2'd2 && dg[2] == 0) ||
                    (scan_i == 2'd1 && dg[2] == 0 && dg[1] == 0);
            check("fnd_com", fnd_com, ecom);
            check("fnd_font", fnd_font, blank ? 8'hFF : font(dg[scan_i]));
            check("fnd_com_nolz", fnd_com2, ecom);
            check("fnd_font_nolz", fnd_font2, font(dg[scan_i]));
        end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // T1: reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_bcd", bcd_out, 12'h000);
        check("rst_com", fnd_com, 4'b1110);
        check("rst_font", fnd_font, 8'hC0);
        rst_n = 1'b1;

        // T2: 510, full scan frame
        send(9'd510, 12'h510);
        wait_idle();
        check_display(510, 16);

        // T3: leading-zero blanking and inner zero
        send(9'd7, 12'h007);
        wait_idle();
        check_display(7, 16);
        send(9'd105, 12'h105);
        wait_idle();
        check_display(105, 16);

        // T4: strobe during conversion is ignored
        @(posedge clk); #1;
        sum_in  = 9'd200;
        sum_vld = 1'b1;
        exp_q.push_back(12'h200);
        @(posedge clk); #1;          // after E0
        sum_vld = 1'b0;
        @(posedge clk); #1;          // after E1
        @(posedge clk); #1;          // after E2
        sum_in  = 9'd99;
        sum_vld = 1'b1;
        @(posedge clk); #1;          // E3 sampled the ignored strobe
        sum_vld = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("ignored_busy", busy, 1'b0);
        check("ignored_bcd", bcd_out, 12'h200);

        // Back-to-back: strobe held high, re-accepted at the edge after E9
        @(posedge clk); #1;
        sum_in  = 9'd511;
        sum_vld = 1'b1;
        exp_q.push_back(12'h511);
        @(posedge clk); #1;          // after E0
        sum_in  = 9'd42;
        exp_q.push_back(12'h042);
        repeat (10) @(posedge clk);  // E1..E9, then E10 accepts 42
        #1;
        sum_vld = 1'b0;
        check("b2b_busy", busy, 1'b1);
        wait_idle();
        check_display(42, 8);

        // T5: reset mid-conversion discards the partial result
        @(posedge clk); #1;
        sum_in  = 9'd300;
        sum_vld = 1'b1;
        @(posedge clk); #1;          // after E0
        sum_vld = 1'b0;
        repeat (4) @(posedge clk);   // E1..E4
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_bcd", bcd_out, 12'h000);
        check("midrst_com", fnd_com, 4'b1110);
        check("midrst_font", fnd_font, 8'hC0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_bcd", bcd_out, 12'h000);
        check_display(0, 16);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
